// File: rtl/rv32i_pkg.sv
// Shared RV32I fetch-path types and constants.
package rv32i_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned ILEN = 32;

    localparam logic [XLEN-1:0] PC_STEP  = 32'd4;
    localparam logic [ILEN-1:0] NOP_INST = 32'h0000_0013;

    // One prefetched instruction together with the address it came from
    typedef struct packed {
        logic [ILEN-1:0] inst;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

    // Force a PC onto a word boundary
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return {pc[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/rv32i_fetch_fifo.sv
// Prefetch FIFO of fetch entries; flush wins over push, head read from storage.
module rv32i_fetch_fifo
    import rv32i_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              i_push,
    input  fetch_entry_t                      i_push_data,
    input  logic                              i_pop,
    input  logic                              i_flush,
    output fetch_entry_t                      o_head,
    output logic [$clog2(DEPTH):0]            o_count,
    output logic                              o_full,
    output logic                              o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    fetch_entry_t    r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;

    logic            w_push_en;
    logic            w_pop_en;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CW'(DEPTH));
    assign w_pop_en  = i_pop & ~o_empty;
    // A push into a full FIFO is only taken when the head leaves the same cycle
    assign w_push_en = i_push & (~o_full | w_pop_en);

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (reset || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_en) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop_en) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= r_count + CW'(w_push_en) - CW'(w_pop_en);
        end
    end

    // Entry storage; not reset, the head is masked while empty
    always_ff @(posedge clk) begin
        if (w_push_en && !i_flush && !reset) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    assign o_head  = o_empty ? '0 : r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/rv32i_fetch_unit.sv
// RV32I instruction fetch: PC, request credits, stale-response discard, RUN/HALT control.
module rv32i_fetch_unit
    import rv32i_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        misaligned
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned SW = CW + 1;

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HALT = 1'b1;

    logic [0:0]      r_state;
    logic [31:0]     r_fetch_pc;
    logic [31:0]     r_rsp_pc;
    logic [CW-1:0]   r_outstanding;
    logic [CW-1:0]   r_discard;
    logic            r_req_valid;
    logic            r_misaligned;

    logic [0:0]      w_state_next;
    logic [31:0]     w_fetch_pc_next;
    logic [31:0]     w_rsp_pc_next;
    logic [CW-1:0]   w_outstanding_next;
    logic [CW-1:0]   w_discard_next;
    logic [CW-1:0]   w_count_next;
    logic            w_req_valid_next;
    logic            w_misaligned_next;

    logic            w_accept;
    logic            w_pop;
    logic            w_push;
    logic            w_redir_misal;
    logic [31:0]     w_redir_pc;

    fetch_entry_t    w_push_data;
    fetch_entry_t    w_head;
    logic [CW-1:0]   w_fifo_count;
    logic            w_fifo_full;
    logic            w_fifo_empty;

    assign w_accept      = r_req_valid & imem_req_ready;
    assign w_pop         = ~w_fifo_empty & inst_ready;
    assign w_redir_misal = redirect_valid & (redirect_pc[1:0] != 2'b00);
    assign w_redir_pc    = align_pc(redirect_pc);
    // Keep a response only when no redirect is killing it and nothing stale is pending
    assign w_push        = imem_rsp_valid & ~redirect_valid & (r_discard == '0)
                           & (~w_fifo_full | w_pop);
    assign w_push_data   = '{inst: imem_rsp_data, pc: r_rsp_pc};

    rv32i_fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .i_flush     (redirect_valid),
        .o_head      (w_head),
        .o_count     (w_fifo_count),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty)
    );

    // Next-state: FSM, PCs, credit and discard counters, registered request valid
    always_comb begin
        w_state_next       = r_state;
        w_fetch_pc_next    = r_fetch_pc;
        w_rsp_pc_next      = r_rsp_pc;
        w_outstanding_next = r_outstanding + CW'(w_accept) - CW'(imem_rsp_valid);
        w_discard_next     = r_discard;
        w_misaligned_next  = r_misaligned;
        w_count_next       = w_fifo_count + CW'(w_push) - CW'(w_pop);

        case (r_state)
            ST_RUN: begin
                if (w_redir_misal) begin
                    w_state_next = ST_HALT;
                end
            end
            ST_HALT: begin
                if (redirect_valid && !w_redir_misal) begin
                    w_state_next = ST_RUN;
                end
            end
            default: begin
                w_state_next = ST_RUN;
            end
        endcase

        if (imem_rsp_valid && (r_discard != '0)) begin
            w_discard_next = r_discard - CW'(1);
        end
        if (w_accept) begin
            w_fetch_pc_next = r_fetch_pc + PC_STEP;
        end
        if (w_push) begin
            w_rsp_pc_next = r_rsp_pc + PC_STEP;
        end

        // Redirect: everything in flight, including this cycle's accept, is stale
        if (redirect_valid) begin
            w_fetch_pc_next   = w_redir_pc;
            w_rsp_pc_next     = w_redir_pc;
            w_discard_next    = w_outstanding_next;
            w_misaligned_next = w_redir_misal;
            w_count_next      = '0;
        end

        w_req_valid_next = (w_state_next == ST_RUN) &&
                           ((SW'(w_count_next) + SW'(w_outstanding_next)) < SW'(DEPTH));
    end

    // State registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_RUN;
            r_fetch_pc    <= RESET_PC;
            r_rsp_pc      <= RESET_PC;
            r_outstanding <= '0;
            r_discard     <= '0;
            r_req_valid   <= 1'b0;
            r_misaligned  <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_fetch_pc    <= w_fetch_pc_next;
            r_rsp_pc      <= w_rsp_pc_next;
            r_outstanding <= w_outstanding_next;
            r_discard     <= w_discard_next;
            r_req_valid   <= w_req_valid_next;
            r_misaligned  <= w_misaligned_next;
        end
    end

    assign imem_req_valid = r_req_valid;
    assign imem_req_addr  = r_fetch_pc;
    assign inst_valid     = ~w_fifo_empty;
    assign inst           = w_head.inst;
    assign inst_pc        = w_head.pc;
    assign misaligned     = r_misaligned;

endmodule

// File: tb/tb_rv32i_fetch_unit.sv
// Directed bench for rv32i_fetch_unit with a fixed-latency in-order memory model.
module tb_rv32i_fetch_unit;
    import rv32i_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int unsigned DEPTH    = 2;

    logic        clk;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        misaligned;

    rv32i_fetch_unit #(
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .misaligned     (misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t        memq[$];
    logic [31:0]  accq[$];
    fetch_entry_t popq[$];
    int           cyc;
    int           lat;
    int           n_vec;
    int           n_err;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hDEAD_0013;
    endfunction

    function automatic logic [31:0] acc_at(input int i);
        if (i < accq.size()) return accq[i];
        return 32'hBAD0_0000;
    endfunction

    function automatic logic [31:0] pop_pc(input int i);
        if (i < popq.size()) return popq[i].pc;
        return 32'hBAD0_0001;
    endfunction

    function automatic logic [31:0] pop_inst(input int i);
        if (i < popq.size()) return popq[i].inst;
        return 32'hBAD0_0002;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One clock: log accept/pop of the ending cycle, then drive next cycle's response
    task automatic tick();
        logic         acc;
        logic         pop;
        logic         rsp;
        logic [31:0]  addr;
        fetch_entry_t pe;
        acc  = imem_req_valid & imem_req_ready & ~reset;
        pop  = inst_valid & inst_ready & ~reset;
        rsp  = imem_rsp_valid;
        addr = imem_req_addr;
        pe   = '{inst: inst, pc: inst_pc};
        @(posedge clk);
        #1;
        cyc++;
        if (rsp && memq.size() > 0) void'(memq.pop_front());
        if (acc) begin
            memq.push_back('{addr: addr, due: cyc - 1 + lat});
            accq.push_back(addr);
        end
        if (pop) popq.push_back(pe);
        if (reset) memq.delete();
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        if (memq.size() > 0 && memq[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(memq[0].addr);
        end
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        redirect_valid = 1'b0;
        imem_rsp_valid = 1'b0;
        memq.delete();
        repeat (2) tick();
        reset = 1'b0;
        accq.delete();
        popq.delete();
    endtask

    task automatic redirect(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        tick();
        redirect_valid = 1'b0;
    endtask

    int first_acc;
    int first_val;
    int cnt;
    int guard;

    initial begin
        n_vec = 0; n_err = 0; cyc = 0; lat = 1;
        reset = 1'b1; imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
        inst_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;

        // Reset state
        repeat (2) tick();
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_req_addr", imem_req_addr, RESET_PC);
        chk("rst_inst_valid", 32'(inst_valid), 32'd0);
        chk("rst_inst", inst, 32'h0);
        chk("rst_inst_pc", inst_pc, 32'h0);
        chk("rst_misaligned", 32'(misaligned), 32'd0);

        // Streaming, 1-cycle memory, core always ready
        do_reset();
        lat = 1; inst_ready = 1'b1;
        first_acc = -1; first_val = -1;
        for (int i = 0; i < 15; i++) begin
            if (imem_req_valid && imem_req_ready && first_acc < 0) first_acc = cyc;
            if (inst_valid && first_val < 0) first_val = cyc;
            tick();
        end
        chk("t1_latency", 32'(first_val - first_acc), 32'd2);
        chk("t1_addr0", acc_at(0), 32'h0);
        chk("t1_addr1", acc_at(1), 32'h4);
        chk("t1_addr2", acc_at(2), 32'h8);
        chk("t1_pc0", pop_pc(0), 32'h0);
        chk("t1_pc1", pop_pc(1), 32'h4);
        chk("t1_pc2", pop_pc(2), 32'h8);
        chk("t1_inst0", pop_inst(0), 32'hDEAD_0013);
        chk("t1_inst2", pop_inst(2), 32'hDEAD_001B);

        // Core stalled: credits cap requests at DEPTH
        do_reset();
        inst_ready = 1'b0;
        repeat (10) tick();
        chk("t2_accepts", 32'(accq.size()), 32'd2);
        chk("t2_req_valid", 32'(imem_req_valid), 32'd0);
        chk("t2_head_pc", inst_pc, 32'h0);
        inst_ready = 1'b1;
        repeat (12) tick();
        chk("t2_pc0", pop_pc(0), 32'h0);
        chk("t2_pc1", pop_pc(1), 32'h4);
        chk("t2_pc2", pop_pc(2), 32'h8);
        chk("t2_addr2", acc_at(2), 32'h8);

        // 3-cycle memory, redirect with two requests in flight
        do_reset();
        lat = 3; inst_ready = 1'b1;
        guard = 0;
        while (!(memq.size() == 2 && !imem_rsp_valid) && guard < 20) begin
            tick();
            guard++;
        end
        chk("t3_setup_timeout", 32'(guard < 20), 32'd1);
        redirect(32'h100);
        accq.delete(); popq.delete();
        repeat (30) tick();
        cnt = 0;
        foreach (popq[i]) if (popq[i].pc < 32'h100) cnt++;
        chk("t3_stale_pops", 32'(cnt), 32'd0);
        chk("t3_addr0", acc_at(0), 32'h100);
        chk("t3_pc0", pop_pc(0), 32'h100);
        chk("t3_inst0", pop_inst(0), 32'hDEAD_0113);
        chk("t3_pc1", pop_pc(1), 32'h104);

        // Misaligned redirect halts fetch until an aligned redirect
        redirect(32'h102);
        chk("t4_misaligned_set", 32'(misaligned), 32'd1);
        chk("t4_inst_valid", 32'(inst_valid), 32'd0);
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (imem_req_valid) cnt++;
            tick();
        end
        chk("t4_halt_req_cycles", 32'(cnt), 32'd0);
        chk("t4_misaligned_sticky", 32'(misaligned), 32'd1);
        redirect(32'h200);
        chk("t4_misaligned_clr", 32'(misaligned), 32'd0);
        accq.delete(); popq.delete();
        repeat (20) tick();
        chk("t4_addr0", acc_at(0), 32'h200);
        chk("t4_pc0", pop_pc(0), 32'h200);

        // Redirect, pop and response arrival in the same cycle
        do_reset();
        lat = 1; inst_ready = 1'b0;
        guard = 0;
        while (!(inst_valid && imem_rsp_valid) && guard < 20) begin
            tick();
            guard++;
        end
        chk("t5_setup_timeout", 32'(guard < 20), 32'd1);
        popq.delete();
        inst_ready = 1'b1;
        redirect(32'h40);
        chk("t5_pops", 32'(popq.size()), 32'd1);
        chk("t5_popped_pc", pop_pc(0), 32'h0);
        chk("t5_inst_valid", 32'(inst_valid), 32'd0);
        popq.delete();
        repeat (15) tick();
        chk("t5_pc0", pop_pc(0), 32'h40);
        chk("t5_inst0", pop_inst(0), 32'hDEAD_0053);

        // Reset with FIFO full
        inst_ready = 1'b0;
        repeat (8) tick();
        chk("t6_full_valid", 32'(inst_valid), 32'd1);
        reset = 1'b1;
        tick();
        chk("t6_inst_valid", 32'(inst_valid), 32'd0);
        chk("t6_req_valid", 32'(imem_req_valid), 32'd0);
        reset = 1'b0;
        accq.delete(); popq.delete();
        inst_ready = 1'b1;
        repeat (10) tick();
        chk("t6_addr0", acc_at(0), RESET_PC);
        chk("t6_pc0", pop_pc(0), RESET_PC);

        // Fetch PC wraps at the top of the address space
        redirect(32'hFFFF_FFFC);
        accq.delete(); popq.delete();
        repeat (12) tick();
        chk("t7_addr0", acc_at(0), 32'hFFFF_FFFC);
        chk("t7_addr1", acc_at(1), 32'h0);
        chk("t7_pc0", pop_pc(0), 32'hFFFF_FFFC);
        chk("t7_pc1", pop_pc(1), 32'h0);
        chk("t7_inst1", pop_inst(1), 32'hDEAD_0013);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
